// File: rtl/usart_rx_deframer.sv
// Serial receiver: start, 8 data bits LSB-first, parity, stop; byte out on transfer/rx_ack.
// Optional break detector output break_det when USART_RX_BREAK_DET_EN is defined.
module usart_rx_deframer #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       transfer,
  input  logic       rx_ack,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
`ifdef USART_RX_BREAK_DET_EN
  ,
  output logic       break_det
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, state_nxt;
  logic            sync1, sync2, sync3;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bit;
  logic            cnt_clr, shift_en, par_en, done;
  logic            perr_new, ferr_new, is_break, deliver;

  // sync3 is the previous synchronised sample, used only for falling-edge detection
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (sync3 && !sync2) begin
          state_nxt = START;
          cnt_clr   = 1'b1;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_clr   = 1'b1;
          state_nxt = sync2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (cnt == FULL_M1) begin
          cnt_clr   = 1'b1;
          par_en    = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_clr   = 1'b1;
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      cnt     <= '0;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      par_bit <= 1'b0;
    end else begin
      cnt <= (cnt_clr || state == IDLE) ? '0 : cnt + CW'(1);
      if (state == IDLE) bit_cnt <= 3'd0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shreg <= {sync2, shreg[7:1]};
      if (par_en) par_bit <= sync2;
    end
  end

  assign perr_new = ^shreg ^ par_bit ^ PARITY_ODD;
  assign ferr_new = ~sync2;
`ifdef USART_RX_BREAK_DET_EN
  assign is_break = done && (shreg == 8'h00) && !par_bit && !sync2;
`else
  assign is_break = 1'b0;
`endif
  assign deliver = done && !is_break;
  assign busy    = (state != IDLE);

  // A completion landing on the ack cycle replaces the byte, so transfer stays high
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      rx_data    <= 8'h00;
      transfer   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (deliver && (!transfer || rx_ack)) begin
      rx_data    <= shreg;
      parity_err <= perr_new;
      frame_err  <= ferr_new;
      transfer   <= 1'b1;
    end else begin
      if (deliver) overrun <= 1'b1;
      if (transfer && rx_ack) transfer <= 1'b0;
    end
  end

`ifdef USART_RX_BREAK_DET_EN
  localparam int HW = $clog2(CLKS_PER_BIT + 1);
  logic [HW-1:0] high_cnt;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      high_cnt  <= '0;
      break_det <= 1'b0;
    end else begin
      if (!sync2) high_cnt <= '0;
      else if (high_cnt != HW'(CLKS_PER_BIT)) high_cnt <= high_cnt + HW'(1);
      if (is_break) break_det <= 1'b1;
      else if (high_cnt == HW'(CLKS_PER_BIT)) break_det <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_usart_rx_deframer.sv
// Randomised scoreboard bench for usart_rx_deframer; a monitor acts as the byte consumer.
module tb_usart_rx_deframer;
  localparam int CPB  = 16;
  localparam bit PODD = 1'b0;
  localparam int LAT  = 10 * CPB + CPB / 2 + 3;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       transfer, parity_err, frame_err, overrun, busy;
`ifdef USART_RX_BREAK_DET_EN
  logic       break_det;
`endif

  usart_rx_deframer #(.CLKS_PER_BIT(CPB), .PARITY_ODD(PODD)) dut (
    .CLK(CLK), .CLR(CLR), .rxd(rxd), .rx_data(rx_data), .transfer(transfer),
    .rx_ack(rx_ack), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
`ifdef USART_RX_BREAK_DET_EN
    , .break_det(break_det)
`endif
  );

  always #10 CLK = ~CLK;

  typedef struct {logic [7:0] d; logic pe; logic fe;} exp_t;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  bit   auto_ack = 1'b1;
  int   ack_req = 0;
  int   ack_done = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: a byte is expected unless suppressed; parity is wrong when the
  // number of ones over data+parity disagrees with the chosen parity sense.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit expect_it);
    exp_t e;
    logic [7:0] dv;
    dv = d;
    if (expect_it) begin
      e.d  = d;
      e.pe = (($countones({d, p}) % 2) == 1) != PODD;
      e.fe = !s;
      q.push_back(e);
    end
    rxd = 1'b0;
    start_cyc = cyc;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rxd = dv[i];
      repeat (CPB) @(negedge CLK);
    end
    rxd = p;
    repeat (CPB) @(negedge CLK);
    rxd = s;
    repeat (CPB) @(negedge CLK);
    rxd = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    repeat (n * CPB) @(negedge CLK);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || transfer) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  // Consumer/monitor: pops and compares each presented byte, then acks it
  initial begin
    exp_t e;
    int lat;
    forever begin
      @(negedge CLK);
      if (CLR && transfer && (auto_ack || ack_req != ack_done)) begin
        if (auto_ack) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=%0h required=none", rx_data);
          end else begin
            e = q.pop_front();
            chk("rx_data", rx_data, e.d);
            chk("parity_err", parity_err, e.pe);
            chk("frame_err", frame_err, e.fe);
            lat = cyc - start_cyc;
            checks++;
            if (lat < LAT - 2 || lat > LAT + 1) begin
              errors++;
              $display("FAIL latency actual=%0d required=%0d", lat, LAT);
            end
          end
        end else begin
          ack_done++;
        end
        rx_ack = 1'b1;
        @(negedge CLK);
        rx_ack = 1'b0;
      end
    end
  end

  initial begin
    logic [7:0] d, v;
    logic p, s;
    int gap;
    bit saw;

    #5 CLR = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_transfer", transfer, 0);
    chk("rst_flags", {parity_err, frame_err, overrun}, 0);
    chk("rst_busy", busy, 0);
    CLR = 1'b1;
    idle_bits(1);

    send_frame(8'h8D, 1'b0, 1'b1, 1'b1);
    idle_bits(2);
    send_frame(8'h8D, 1'b1, 1'b1, 1'b1);
    idle_bits(2);
    send_frame(8'h8D, 1'b0, 1'b0, 1'b1);
    idle_bits(2);

    for (int k = 0; k < 20; k++) begin
      d = 8'($urandom);
      p = ($urandom_range(0, 9) < 7) ? ((^d) ^ PODD) : !((^d) ^ PODD);
      s = ($urandom_range(0, 4) != 0);
      if (d == 8'h00 && !p) s = 1'b1;
      gap = $urandom_range(0, 2);
      if (!s && gap == 0) gap = 1;
      send_frame(d, p, s, 1'b1);
      idle_bits(gap);
    end
    idle_bits(1);
    wait_drain(400);
    chk("no_overrun_yet", overrun, 0);

    auto_ack = 1'b0;
    send_frame(8'h8D, 1'b0, 1'b1, 1'b0);
    send_frame(8'h72, 1'b0, 1'b1, 1'b0);
    idle_bits(2);
    chk("ovr_transfer", transfer, 1);
    chk("ovr_rx_data", rx_data, 8'h8D);
    chk("ovr_flag", overrun, 1);
    ack_req++;
    repeat (4) @(negedge CLK);
    chk("ovr_ack_transfer", transfer, 0);
    chk("ovr_sticky", overrun, 1);
    auto_ack = 1'b1;

    rxd = 1'b0;
    repeat (5) @(negedge CLK);
    rxd = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 3 * CPB; i++) begin
      saw |= busy;
      @(negedge CLK);
    end
    chk("glitch_busy_seen", saw, 1);
    chk("glitch_idle", busy, 0);
    chk("glitch_transfer", transfer, 0);

    v = 8'h3C;
    rxd = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      rxd = v[i];
      repeat ((i == 4) ? CPB / 2 : CPB) @(negedge CLK);
    end
    chk("mid_busy", busy, 1);
    CLR = 1'b0;
    #1;
    chk("clr_rx_data", rx_data, 8'h00);
    chk("clr_overrun", overrun, 0);
    chk("clr_busy", busy, 0);
    chk("clr_transfer", transfer, 0);
    rxd = 1'b1;
    @(negedge CLK);
    CLR = 1'b1;
    idle_bits(3);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    idle_bits(2);
    wait_drain(200);

`ifdef USART_RX_BREAK_DET_EN
    rxd = 1'b0;
    repeat (12 * CPB) @(negedge CLK);
    chk("break_set", break_det, 1);
    chk("break_no_transfer", transfer, 0);
    rxd = 1'b1;
    repeat (CPB - 4) @(negedge CLK);
    chk("break_hold", break_det, 1);
    repeat (10) @(negedge CLK);
    chk("break_clear", break_det, 0);
`else
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    idle_bits(2);
    wait_drain(200);
`endif
    chk("final_overrun", overrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
